step_sequencer_core: RTL and testbench

- Multi-track step sequencer engine; successor to the single-track beat/pitch controller.
- Advances a shared beat position at a runtime-programmable step interval.
- Per step, presents each track's note code and a gate of programmable length.
- Supports play/stop, restart, variable loop length and per-track mute; outputs feed downstream per-track pwm_decoder/pwm_generator pairs.

---
 rtl/step_sequencer_core.sv | 199 +++++++++++++++++++
 tb/tb_step_sequencer_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer_core.sv
// rtl/step_sequencer_core.sv - multi-track step sequencer engine; optional swing timing under SWING_EN
module step_sequencer_core #(
    parameter int NUM_BEATS  = 16,
    parameter int NUM_TRACKS = 2,
    parameter int NOTE_W     = 4,
    parameter int CNT_W      = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   play,
    input  logic                                   restart,
    input  logic [NUM_TRACKS*NUM_BEATS*NOTE_W-1:0] beats,
    input  logic [CNT_W-1:0]                       step_interval,
    input  logic [CNT_W-1:0]                       gate_len,
    input  logic [$clog2(NUM_BEATS):0]             loop_len,
    input  logic [NUM_TRACKS-1:0]                  track_mute,
    input  logic [CNT_W-1:0]                       swing_amt,
    output logic [$clog2(NUM_BEATS)-1:0]           beat_count,
    output logic                                   step_pulse,
    output logic                                   running,
    output logic [NUM_TRACKS*NOTE_W-1:0]           note_out,
    output logic [NUM_TRACKS-1:0]                  gate
);

    localparam int BW = $clog2(NUM_BEATS);
    localparam int LW = BW + 1;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CNT_W-1:0]               len_q, len_d;
    logic [CNT_W-1:0]               gate_len_q, gate_len_d;
    logic                           pulse_q, pulse_d;
    logic [NUM_TRACKS*NOTE_W-1:0]   note_q, note_d;
    logic [NUM_TRACKS-1:0]          gate_q, gate_d;

    logic [LW-1:0]                  eff_len;
    logic [LW-1:0]                  beat_inc;
    logic [BW-1:0]                  next_beat;
    logic [CNT_W-1:0]               iv_clamped;
    logic [CNT_W-1:0]               step_len;
    logic                           boundary;
    logic                           start_step;
    logic                           clear_pos;
    logic [BW-1:0]                  tgt;
    logic [NUM_TRACKS*NOTE_W-1:0]   sel_note;
    logic [NUM_TRACKS-1:0]          sel_gate;

    // Loop length 0 or beyond the pattern plays the whole pattern; >= also catches a shrunk loop.
    assign eff_len    = (loop_len == '0 || loop_len > LW'(NUM_BEATS)) ? LW'(NUM_BEATS) : loop_len;
    assign beat_inc   = {1'b0, beat_q} + LW'(1);
    assign next_beat  = (beat_inc >= eff_len) ? '0 : beat_inc[BW-1:0];
    assign iv_clamped = (step_interval < CNT_W'(2)) ? CNT_W'(2) : step_interval;
    assign boundary   = (cnt_q == len_q - CNT_W'(1));

`ifdef SWING_EN
    logic [CNT_W-1:0] swing_max;
    logic [CNT_W-1:0] swing_s;

    // Even steps stretch and odd steps shrink by the same amount so a pair keeps its length.
    always_comb begin
        swing_max = (iv_clamped >> 1) - CNT_W'(1);
        swing_s   = (swing_amt < swing_max) ? swing_amt : swing_max;
        step_len  = tgt[0] ? (iv_clamped - swing_s) : (iv_clamped + swing_s);
    end
`else
    logic unused_swing;
    assign unused_swing = ^swing_amt;

    // Without swing every step lasts the clamped interval.
    always_comb begin
        step_len = iv_clamped;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: play level alone moves between stopped and running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: if (play)  state_d = ST_RUNNING;
            ST_RUNNING: if (!play) state_d = ST_STOPPED;
            default:    state_d = ST_STOPPED;
        endcase
    end

    // Decide whether this edge starts a step and which beat it lands on; restart beats a boundary.
    always_comb begin
        start_step = 1'b0;
        clear_pos  = 1'b0;
        tgt        = beat_q;
        case (state_q)
            ST_STOPPED: begin
                clear_pos = restart;
                if (play) begin
                    start_step = 1'b1;
                    tgt        = restart ? '0 : beat_q;
                end
            end
            ST_RUNNING: begin
                if (!play) begin
                    clear_pos = restart;
                end else if (restart) begin
                    start_step = 1'b1;
                    tgt        = '0;
                end else if (boundary) begin
                    start_step = 1'b1;
                    tgt        = next_beat;
                end
            end
            default: ;
        endcase
    end

    // Note codes and gate enables for the beat a step start would land on.
    always_comb begin
        sel_note = '0;
        sel_gate = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            sel_note[t*NOTE_W +: NOTE_W] = beats[(t*NUM_BEATS + int'(tgt))*NOTE_W +: NOTE_W];
            sel_gate[t] = (sel_note[t*NOTE_W +: NOTE_W] != '0) && !track_mute[t] && (gate_len != '0);
        end
    end

    // Datapath next state: latch step parameters at a start, count and clear gate mid-step, idle when stopped.
    always_comb begin
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        gate_len_d = gate_len_q;
        pulse_d    = 1'b0;
        note_d     = note_q;
        gate_d     = gate_q;
        if (start_step) begin
            beat_d     = tgt;
            cnt_d      = '0;
            pulse_d    = 1'b1;
            len_d      = step_len;
            gate_len_d = gate_len;
            note_d     = sel_note;
            gate_d     = sel_gate;
        end else if (state_q == ST_RUNNING && play) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == gate_len_q) begin
                gate_d = '0;
            end
        end else begin
            cnt_d  = '0;
            gate_d = '0;
            if (clear_pos) begin
                beat_d = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q     <= '0;
            cnt_q      <= '0;
            len_q      <= CNT_W'(2);
            gate_len_q <= '0;
            pulse_q    <= 1'b0;
            note_q     <= '0;
            gate_q     <= '0;
        end else begin
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            gate_len_q <= gate_len_d;
            pulse_q    <= pulse_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
        end
    end

    // Outputs.
    always_comb begin
        running    = (state_q == ST_RUNNING);
        beat_count = beat_q;
        step_pulse = pulse_q;
        note_out   = note_q;
        gate       = gate_q;
    end

endmodule

// File: tb/tb_step_sequencer_core.sv
// tb/tb_step_sequencer_core.sv - directed self-checking bench for step_sequencer_core
module tb_step_sequencer_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        play;
    logic        restart;
    logic [31:0] beats;
    logic [31:0] step_interval;
    logic [31:0] gate_len;
    logic [2:0]  loop_len;
    logic [1:0]  track_mute;
    logic [31:0] swing_amt;
    logic [1:0]  beat_count;
    logic        step_pulse;
    logic        running;
    logic [7:0]  note_out;
    logic [1:0]  gate;

    int n_checks = 0;
    int n_fail   = 0;
    int n0[4] = '{1, 5, 3, 7};
    int n1[4] = '{2, 0, 4, 6};
    int b;
    int ph;

`ifdef SWING_EN
    localparam int SW = 3;
`else
    localparam int SW = 0;
`endif

    step_sequencer_core #(
        .NUM_BEATS (4),
        .NUM_TRACKS(2),
        .NOTE_W    (4),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .play         (play),
        .restart      (restart),
        .beats        (beats),
        .step_interval(step_interval),
        .gate_len     (gate_len),
        .loop_len     (loop_len),
        .track_mute   (track_mute),
        .swing_amt    (swing_amt),
        .beat_count   (beat_count),
        .step_pulse   (step_pulse),
        .running      (running),
        .note_out     (note_out),
        .gate         (gate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int exp_beat, input int exp_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 100);
        check("pulse_cycles", 32'(n), 32'(exp_cyc));
        check("pulse_beat", 32'(beat_count), 32'(exp_beat));
    endtask

    initial begin
        rst           = 1'b1;
        play          = 1'b0;
        restart       = 1'b0;
        beats         = 32'h6402_7351;
        step_interval = 32'd5;
        gate_len      = 32'd2;
        loop_len      = 3'd0;
        track_mute    = 2'b00;
        swing_amt     = 32'd0;
        tick();
        tick();
        check("rst_beat", 32'(beat_count), 32'd0);
        check("rst_pulse", 32'(step_pulse), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_note", 32'(note_out), 32'd0);
        check("rst_gate", 32'(gate), 32'd0);

        rst  = 1'b0;
        play = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            b  = ((k - 1) / 5) % 4;
            ph = (k - 1) % 5;
            check("pb_pulse", 32'(step_pulse), (ph == 0) ? 32'd1 : 32'd0);
            check("pb_beat", 32'(beat_count), 32'(b));
            check("pb_note", 32'(note_out), 32'(n1[b] * 16 + n0[b]));
            check("pb_gate", 32'(gate), (ph < 2) ? ((n1[b] != 0) ? 32'd3 : 32'd1) : 32'd0);
        end

        #2;
        rst  = 1'b1;
        play = 1'b0;
        #1;
        check("arst_beat", 32'(beat_count), 32'd0);
        check("arst_pulse", 32'(step_pulse), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_note", 32'(note_out), 32'd0);
        check("arst_gate", 32'(gate), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_running", 32'(running), 32'd0);
        check("post_rst_beat", 32'(beat_count), 32'd0);

        loop_len = 3'd3;
        play     = 1'b1;
        wait_pulse(0, 1);
        wait_pulse(1, 5);
        wait_pulse(2, 5);
        wait_pulse(0, 5);
        wait_pulse(1, 5);
        wait_pulse(2, 5);
        loop_len = 3'd2;
        wait_pulse(0, 5);
        wait_pulse(1, 5);
        wait_pulse(0, 5);

        track_mute = 2'b01;
        wait_pulse(1, 5);
        check("mute_note", 32'(note_out), 32'h05);
        check("mute_gate", 32'(gate), 32'd0);
        track_mute    = 2'b00;
        step_interval = 32'd0;
        tick();
        check("mute_live_gate", 32'(gate), 32'd0);

        wait_pulse(0, 4);
        wait_pulse(1, 2);
        wait_pulse(0, 2);

        step_interval = 32'd5;
        gate_len      = 32'd10;
        loop_len      = 3'd0;
        wait_pulse(1, 2);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("legato_gate0", 32'(gate[0]), 32'd1);
        end
        wait_pulse(2, 5);

        play = 1'b0;
        tick();
        check("stop_running", 32'(running), 32'd0);
        check("stop_gate", 32'(gate), 32'd0);
        check("stop_beat", 32'(beat_count), 32'd2);
        check("stop_pulse", 32'(step_pulse), 32'd0);
        tick();
        check("stop_hold_beat", 32'(beat_count), 32'd2);
        play = 1'b1;
        tick();
        check("resume_pulse", 32'(step_pulse), 32'd1);
        check("resume_beat", 32'(beat_count), 32'd2);
        check("resume_running", 32'(running), 32'd1);
        check("resume_note", 32'(note_out), 32'h43);
        wait_pulse(3, 5);
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_pulse", 32'(step_pulse), 32'd1);
        check("restart_beat", 32'(beat_count), 32'd0);
        wait_pulse(1, 5);

        play = 1'b0;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("srestart_beat", 32'(beat_count), 32'd0);
        check("srestart_pulse", 32'(step_pulse), 32'd0);
        check("srestart_gate", 32'(gate), 32'd0);

        play          = 1'b1;
        restart       = 1'b1;
        step_interval = 32'd10;
        swing_amt     = 32'd3;
        gate_len      = 32'd2;
        tick();
        restart = 1'b0;
        check("swing_start_pulse", 32'(step_pulse), 32'd1);
        check("swing_start_beat", 32'(beat_count), 32'd0);
        wait_pulse(1, 10 + SW);
        wait_pulse(2, 10 - SW);
        wait_pulse(3, 10 + SW);
        wait_pulse(0, 10 - SW);

        play = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
